// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO word reader.
// Lane placement honours FIFO_WORD_READER_SWAP_EN through the packer's swap flag.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } e_reader_state;

  localparam int unsigned MAX_WORD_BYTES = 4;
  localparam int unsigned CNT_W          = $clog2(MAX_WORD_BYTES + 1);

  // Maps the n-th captured byte to its lane; swapped packing fills from the top lane down.
  function automatic logic [CNT_W-1:0] lane_of(input logic [CNT_W-1:0] idx,
                                               input int unsigned       word_bytes,
                                               input logic              swap);
    if (swap) begin
      lane_of = CNT_W'(word_bytes - 1) - idx;
    end else begin
      lane_of = idx;
    end
  endfunction

endpackage

// File: rtl/fifo_byte_packer.sv
// Collects bytes into lanes of one output word and tracks the lane-valid mask.
// FIFO_WORD_READER_SWAP_EN selects big-endian (MSB-first) lane order.
module fifo_byte_packer
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    clear_i,
  input  logic                    capture_i,
  input  logic [7:0]              byte_i,
  output logic [CNT_W-1:0]        cap_cnt_o,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic [WORD_BYTES-1:0]   byte_en_o
);

`ifdef FIFO_WORD_READER_SWAP_EN
  localparam logic SWAP = 1'b1;
`else
  localparam logic SWAP = 1'b0;
`endif

  logic [CNT_W-1:0]        cnt_q,  cnt_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [WORD_BYTES-1:0]   en_q,   en_d;
  logic [CNT_W-1:0]        lane_c;

  // Clear wins over capture so an abort drops any byte arriving the same cycle.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    en_d   = en_q;
    lane_c = lane_of(cnt_q, WORD_BYTES, SWAP);
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
      en_d   = '0;
    end else if (capture_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        if (lane_c == CNT_W'(i)) begin
          word_d[8*i +: 8] = byte_i;
          en_d[i]          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      word_q <= '0;
      en_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      en_q   <= en_d;
    end
  end

  assign cap_cnt_o = cnt_q;
  assign word_o    = word_q;
  assign byte_en_o = en_q;

endmodule

// File: rtl/fifo_word_reader.sv
// Drains a programmed byte count from an 8-bit FIFO and presents packed words on a valid/ready stream.
// Optional FIFO_WORD_READER_SWAP_EN gives big-endian lane order (handled in fifo_byte_packer).
module fifo_word_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_WIDTH-1:0]    length,
  output logic                    busy,
  output logic                    done,
  input  logic                    fifo_empty,
  output logic                    fifo_read,
  input  logic [7:0]              fifo_rdata,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic [WORD_BYTES-1:0]   word_byte_en
);

  e_reader_state        state_q;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic [CNT_W-1:0]     req_q;
  logic                 fifo_read_q;
  logic                 rvalid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 word_valid_q;

  logic [CNT_W-1:0]     cap_cnt;
  logic [CNT_W-1:0]     cap_next_c;
  logic                 word_done_c;
  logic                 can_read_c;
  logic                 accept_c;
  logic                 pack_clear_c;
  logic [LEN_WIDTH-1:0] rem_after_c;

  // Reads alternate with a idle cycle so the registered strobe never outruns the empty flag.
  always_comb begin
    cap_next_c   = cap_cnt + CNT_W'(rvalid_q);
    word_done_c  = (cap_next_c == CNT_W'(WORD_BYTES)) ||
                   (LEN_WIDTH'(cap_next_c) == remaining_q);
    can_read_c   = !fifo_empty && !fifo_read_q &&
                   (LEN_WIDTH'(req_q) < remaining_q) &&
                   (req_q < CNT_W'(WORD_BYTES));
    accept_c     = word_valid_q && word_ready;
    rem_after_c  = remaining_q - LEN_WIDTH'(cap_cnt);
    pack_clear_c = abort || ((state_q == PRESENT) && accept_c);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      req_q        <= '0;
      fifo_read_q  <= 1'b0;
      rvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_valid_q <= 1'b0;
    end else if (abort) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      req_q        <= '0;
      fifo_read_q  <= 1'b0;
      rvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_valid_q <= 1'b0;
    end else begin
      rvalid_q    <= fifo_read_q;
      fifo_read_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            remaining_q <= length;
            req_q       <= '0;
            if (length == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= FILL;
              if (!fifo_empty) begin
                fifo_read_q <= 1'b1;
                req_q       <= CNT_W'(1);
              end
            end
          end
        end
        FILL: begin
          if (word_done_c) begin
            state_q      <= PRESENT;
            word_valid_q <= 1'b1;
          end else if (can_read_c) begin
            fifo_read_q <= 1'b1;
            req_q       <= req_q + CNT_W'(1);
          end
        end
        PRESENT: begin
          if (accept_c) begin
            word_valid_q <= 1'b0;
            req_q        <= '0;
            remaining_q  <= rem_after_c;
            if (rem_after_c != '0) begin
              state_q <= FILL;
            end else begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fifo_byte_packer #(
    .WORD_BYTES(WORD_BYTES)
  ) u_packer (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .clear_i   (pack_clear_c),
    .capture_i (rvalid_q),
    .byte_i    (fifo_rdata),
    .cap_cnt_o (cap_cnt),
    .word_o    (word_data),
    .byte_en_o (word_byte_en)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_read  = fifo_read_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader (WORD_BYTES=4) with a behavioural FIFO and stream monitor.
module tb_fifo_word_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        fifo_empty;
  logic        fifo_read;
  logic [7:0]  fifo_rdata;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [3:0]  word_byte_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_word_reader #(.WORD_BYTES(4), .LEN_WIDTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .fifo_empty   (fifo_empty),
    .fifo_read    (fifo_read),
    .fifo_rdata   (fifo_rdata),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_data    (word_data),
    .word_byte_en (word_byte_en)
  );

  // Behavioural FIFO: data appears the cycle after the read strobe.
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 8'd1;
    end
  end

  // Stream monitor sampled mid-cycle.
  int          n_reads = 0, n_bad = 0, n_done = 0, n_vcyc = 0, n_unstable = 0, n_words = 0;
  logic [31:0] acc_data [0:63];
  logic [3:0]  acc_en   [0:63];
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_data  = '0;

  always @(negedge clk) begin
    if (fifo_read) n_reads <= n_reads + 1;
    if (fifo_read && fifo_empty) n_bad <= n_bad + 1;
    if (done) n_done <= n_done + 1;
    if (word_valid) n_vcyc <= n_vcyc + 1;
    if (word_valid && word_ready) begin
      acc_data[n_words] <= word_data;
      acc_en[n_words]   <= word_byte_en;
      n_words           <= n_words + 1;
    end
    if (prev_valid && !prev_ready && (!word_valid || word_data !== prev_data))
      n_unstable <= n_unstable + 1;
    prev_valid <= word_valid;
    prev_ready <= word_ready;
    prev_data  <= word_data;
  end

  function automatic logic [31:0] exp_d(input logic [31:0] le);
`ifdef FIFO_WORD_READER_SWAP_EN
    exp_d = {le[7:0], le[15:8], le[23:16], le[31:24]};
`else
    exp_d = le;
`endif
  endfunction

  function automatic logic [3:0] exp_e(input logic [3:0] le);
`ifdef FIFO_WORD_READER_SWAP_EN
    exp_e = {le[0], le[1], le[2], le[3]};
`else
    exp_e = le;
`endif
  endfunction

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_xfer(input logic [15:0] len);
    @(posedge clk); #1;
    start  = 1'b1;
    length = len;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout busy=%b required=0", name, busy);
    end
    cycles(3);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!word_valid && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (word_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout word_valid=%b required=1", name, word_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; length = '0; word_ready = 1'b0;
    cycles(3);
    @(negedge clk);
    checks += 6;
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (done !== 1'b0)         begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    if (fifo_read !== 1'b0)    begin errors++; $display("FAIL rst_fifo_read got=%b exp=0", fifo_read); end
    if (word_valid !== 1'b0)   begin errors++; $display("FAIL rst_word_valid got=%b exp=0", word_valid); end
    if (word_data !== 32'h0)   begin errors++; $display("FAIL rst_word_data got=%h exp=0", word_data); end
    if (word_byte_en !== 4'h0) begin errors++; $display("FAIL rst_byte_en got=%h exp=0", word_byte_en); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_full_words();
    int r0, d0, w0;
    r0 = n_reads; d0 = n_done; w0 = n_words;
    for (int i = 1; i <= 8; i++) push(8'(i));
    word_ready = 1'b1;
    start_xfer(16'd8);
    wait_idle("full");
    checks += 7;
    if (n_words - w0 !== 2) begin errors++; $display("FAIL full_nwords got=%0d exp=2", n_words - w0); end
    if (acc_data[w0] !== exp_d(32'h04030201)) begin errors++; $display("FAIL full_w0 got=%h exp=%h", acc_data[w0], exp_d(32'h04030201)); end
    if (acc_en[w0] !== 4'hF) begin errors++; $display("FAIL full_en0 got=%h exp=f", acc_en[w0]); end
    if (acc_data[w0+1] !== exp_d(32'h08070605)) begin errors++; $display("FAIL full_w1 got=%h exp=%h", acc_data[w0+1], exp_d(32'h08070605)); end
    if (acc_en[w0+1] !== 4'hF) begin errors++; $display("FAIL full_en1 got=%h exp=f", acc_en[w0+1]); end
    if (n_done - d0 !== 1) begin errors++; $display("FAIL full_done got=%0d exp=1", n_done - d0); end
    if (n_reads - r0 !== 8) begin errors++; $display("FAIL full_reads got=%0d exp=8", n_reads - r0); end
  endtask

  task automatic test_partial();
    int r0, d0, w0;
    r0 = n_reads; d0 = n_done; w0 = n_words;
    for (int i = 1; i <= 6; i++) push(8'(i));
    start_xfer(16'd6);
    wait_idle("part");
    checks += 6;
    if (acc_data[w0] !== exp_d(32'h04030201)) begin errors++; $display("FAIL part_w0 got=%h exp=%h", acc_data[w0], exp_d(32'h04030201)); end
    if (acc_data[w0+1] !== exp_d(32'h00000605)) begin errors++; $display("FAIL part_w1 got=%h exp=%h", acc_data[w0+1], exp_d(32'h00000605)); end
    if (acc_en[w0+1] !== exp_e(4'h3)) begin errors++; $display("FAIL part_en1 got=%h exp=%h", acc_en[w0+1], exp_e(4'h3)); end
    if (n_words - w0 !== 2) begin errors++; $display("FAIL part_nwords got=%0d exp=2", n_words - w0); end
    if (n_reads - r0 !== 6) begin errors++; $display("FAIL part_reads got=%0d exp=6", n_reads - r0); end
    if (n_done - d0 !== 1) begin errors++; $display("FAIL part_done got=%0d exp=1", n_done - d0); end
  endtask

  task automatic test_zero_length();
    int r0, v0;
    r0 = n_reads; v0 = n_vcyc;
    start_xfer(16'd0);
    @(negedge clk);
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
    if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_hi got=%b exp=1", busy); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_lo got=%b exp=0", busy); end
    cycles(3);
    checks += 2;
    if (n_reads - r0 !== 0) begin errors++; $display("FAIL zero_reads got=%0d exp=0", n_reads - r0); end
    if (n_vcyc - v0 !== 0) begin errors++; $display("FAIL zero_valid got=%0d exp=0", n_vcyc - v0); end
  endtask

  task automatic test_stall();
    int r0, b0, u0, w0;
    r0 = n_reads; b0 = n_bad; u0 = n_unstable; w0 = n_words;
    word_ready = 1'b0;
    push(8'h21); push(8'h22);
    start_xfer(16'd4);
    cycles(10);
    checks += 2;
    if (n_reads - r0 !== 2) begin errors++; $display("FAIL stall_reads_mid got=%0d exp=2", n_reads - r0); end
    if (word_valid !== 1'b0) begin errors++; $display("FAIL stall_early_valid got=%b exp=0", word_valid); end
    push(8'h23); push(8'h24);
    wait_valid("stall");
    cycles(3);
    word_ready = 1'b1;
    wait_idle("stall");
    checks += 5;
    if (acc_data[w0] !== exp_d(32'h24232221)) begin errors++; $display("FAIL stall_word got=%h exp=%h", acc_data[w0], exp_d(32'h24232221)); end
    if (acc_en[w0] !== 4'hF) begin errors++; $display("FAIL stall_en got=%h exp=f", acc_en[w0]); end
    if (n_unstable - u0 !== 0) begin errors++; $display("FAIL stall_unstable got=%0d exp=0", n_unstable - u0); end
    if (n_bad - b0 !== 0) begin errors++; $display("FAIL stall_read_empty got=%0d exp=0", n_bad - b0); end
    if (n_reads - r0 !== 4) begin errors++; $display("FAIL stall_reads got=%0d exp=4", n_reads - r0); end
  endtask

  task automatic test_abort();
    int r0, d0, w0, k;
    r0 = n_reads; d0 = n_done;
    push(8'h31); push(8'h32); push(8'h33);
    start_xfer(16'd8);
    k = 0;
    while (!fifo_read && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (fifo_read !== 1'b1) begin errors++; $display("FAIL abort_no_read fifo_read=%b exp=1", fifo_read); end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (fifo_read !== 1'b0)  begin errors++; $display("FAIL abort_read got=%b exp=0", fifo_read); end
    if (word_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", word_valid); end
    cycles(3);
    checks += 2;
    if (n_done - d0 !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", n_done - d0); end
    if (n_reads - r0 !== 1) begin errors++; $display("FAIL abort_reads got=%0d exp=1", n_reads - r0); end
    w0 = n_words;
    push(8'h34); push(8'h35);
    start_xfer(16'd4);
    wait_idle("abort_next");
    checks += 2;
    if (acc_data[w0] !== exp_d(32'h35343332)) begin errors++; $display("FAIL abort_next_word got=%h exp=%h", acc_data[w0], exp_d(32'h35343332)); end
    if (acc_en[w0] !== 4'hF) begin errors++; $display("FAIL abort_next_en got=%h exp=f", acc_en[w0]); end
  endtask

  task automatic test_reset_in_present();
    word_ready = 1'b0;
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    start_xfer(16'd4);
    wait_valid("rstp");
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks += 6;
    if (busy !== 1'b0)         begin errors++; $display("FAIL rstp_busy got=%b exp=0", busy); end
    if (done !== 1'b0)         begin errors++; $display("FAIL rstp_done got=%b exp=0", done); end
    if (fifo_read !== 1'b0)    begin errors++; $display("FAIL rstp_read got=%b exp=0", fifo_read); end
    if (word_valid !== 1'b0)   begin errors++; $display("FAIL rstp_valid got=%b exp=0", word_valid); end
    if (word_data !== 32'h0)   begin errors++; $display("FAIL rstp_data got=%h exp=0", word_data); end
    if (word_byte_en !== 4'h0) begin errors++; $display("FAIL rstp_en got=%h exp=0", word_byte_en); end
    @(posedge clk); #1;
    reset_n    = 1'b1;
    word_ready = 1'b1;
    cycles(1);
    start_xfer(16'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL rstp_idle_done got=%b exp=1", done); end
    cycles(3);
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_zero_length();
    test_stall();
    test_abort();
    test_reset_in_present();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
